// File: rtl/vga_ram_arbiter.sv
// Shares the video/text RAM between the VGA pixel generator and the CPU port.
// Define VGA_ARB_STALL_CNT_EN to add the cpu_stall_cnt output.
module vga_ram_arbiter #(
  parameter logic [3:0] VGA_SLOT_MASK = 4'b1011,
  parameter int         RAM_AW        = 14,
  parameter int         RAM_DW        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic              vga_active,
  input  logic [RAM_AW-1:0] vga_addr,
  output logic [RAM_DW-1:0] vga_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [RAM_DW-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [RAM_DW-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [RAM_DW-1:0] ram_rdata
`ifdef VGA_ARB_STALL_CNT_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  logic [1:0]        phase;
  logic              rd_pend;
  logic [RAM_DW-1:0] rdata_hold;
  logic              vga_own;
  logic              grant;

  // The vga_req cycle is always VGA-owned, whatever the phase.
  assign vga_own = vga_req | (vga_active & VGA_SLOT_MASK[phase]);
  assign grant   = rst_n & cpu_req & ~vga_own;

  assign cpu_ack   = grant;
  assign ram_addr  = grant ? cpu_addr : vga_addr;
  assign ram_we    = grant & cpu_we;
  assign ram_wdata = cpu_wdata;
  assign vga_data  = ram_rdata;

  // Read data comes straight from the RAM output register on the return
  // cycle and is held afterwards; a read in flight at reset is dropped.
  assign cpu_rvalid = rst_n & rd_pend;
  assign cpu_rdata  = !rst_n ? '0 : (rd_pend ? ram_rdata : rdata_hold);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= 2'd0;
      rd_pend    <= 1'b0;
      rdata_hold <= '0;
    end else begin
      phase   <= vga_req ? 2'd0 : phase + 2'd1;
      rd_pend <= grant & ~cpu_we;
      if (rd_pend) rdata_hold <= ram_rdata;
    end
  end

`ifdef VGA_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_stall_cnt <= 16'd0;
    end else if (cpu_req && !grant && cpu_stall_cnt != 16'hFFFF) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
